usb_rx_framer: RTL and testbench
================================

Name: usb_rx_framer

Overview:
- Sits directly downstream of the FT600-style USB FIFO bridge.
- Consumes the bridge's 16-bit read words and delimits them into frames of [header, payload..., check].
- Forwards payload words on a valid/ready stream to application logic and reports per-frame OK/ERR status.
- Provides backpressure to the bridge through IN_READY, so the bridge does not start a new read cycle while IN_READY=0.

Parameters:
- SYNC, 8'hA5, required value of header bits [15:8].
- TIMEOUT, 1000, max CLK cycles allowed between consecutive words inside a frame.
- CNT_W, 8, width of the frame_count and drop_count status counters.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- IN_DATA  in  16  word captured by bridge.
- IN_BE  in  2  byte enables for IN_DATA; 2'b11 = full word.
- IN_VALID  in  1  one-cycle strobe; IN_DATA/IN_BE valid.
- IN_READY  out  1  framer can accept a word this cycle.
- PAY_DATA  out  16  payload word.
- PAY_VALID  out  1  PAY_DATA valid.
- PAY_READY  in  1  consumer accepts PAY_DATA.
- PAY_LAST  out  1  qualifies the final payload word of a frame.
- FRAME_OK  out  1  one-cycle pulse: frame checked good.
- FRAME_ERR  out  1  one-cycle pulse: frame aborted or bad.
- ERR_CODE  out  2  valid with FRAME_ERR: 0 checksum, 1 LEN=0, 2 partial BE, 3 timeout.
- frame_count  out  CNT_W  saturating count of good frames.
- drop_count  out  CNT_W  saturating count of words discarded while hunting.

Behaviour:
- Reset (async assert, sync deassert handled by the flop clear):
  - state=HUNT.
  - PAY_VALID, PAY_LAST, FRAME_OK, FRAME_ERR = 0.
  - ERR_CODE=0, PAY_DATA=0, counters=0, sum=0, remaining=0, timer=0.
- Reset asserted mid-frame aborts silently; no FRAME_ERR pulse.
- Word accept = IN_VALID && IN_READY. If IN_VALID arrives while IN_READY=0, the word is lost; the bridge guarantees this does not happen.
- IN_READY = (state != PAYLOAD) || !PAY_VALID || PAY_READY.
- HUNT:
  - If the accepted word has [15:8]==SYNC and BE==2'b11:
    - LEN = [7:0]. If LEN==0, pulse FRAME_ERR with code 1 and stay in HUNT.
    - Otherwise remaining<=LEN, sum<=word, timer<=0, go to PAYLOAD.
  - Any other word: drop it, drop_count+1 (saturating).
- PAYLOAD, on each accepted word:
  - BE!=2'b11: FRAME_ERR code 2, go to HUNT; the word is not forwarded.
  - Otherwise register the word onto PAY_DATA, PAY_VALID<=1, sum<=sum+word (mod 2^16).
  - PAY_LAST<=(remaining==1); remaining-1. When remaining reaches 0, go to CHECK.
- Payload output register:
  - PAY_VALID clears on PAY_READY unless a new word loads in the same cycle.
  - PAY_DATA, PAY_LAST, PAY_VALID are stable while PAY_VALID && !PAY_READY.
  - Latency from accepted input word to PAY_VALID is 1 cycle.
- CHECK, on the accepted word:
  - BE!=2'b11: FRAME_ERR code 2.
  - Word==sum: FRAME_OK, frame_count+1 (saturating).
  - Otherwise: FRAME_ERR code 0.
  - Always return to HUNT.
- Timeout:
  - In PAYLOAD and CHECK, timer increments each cycle with no accepted word and clears on accept.
  - Timer counts only while IN_READY=1; a stalled consumer never causes a timeout.
  - When timer reaches TIMEOUT: FRAME_ERR code 3, go to HUNT.
- Abort behaviour: payload already forwarded stays forwarded, and no PAY_LAST is generated. The consumer discards the in-flight frame on FRAME_ERR.
- FRAME_OK/FRAME_ERR are registered, mutually exclusive, one cycle wide. ERR_CODE holds its value until the next FRAME_ERR.
- A header may be accepted in the cycle after CHECK; back-to-back frames incur no bubble.

Decomposition:
- Shared package usb_pkg holds:
  - state encoding HUNT/PAYLOAD/CHECK;
  - ERR_CODE constants ERR_CSUM=0, ERR_LEN=1, ERR_BE=2, ERR_TMO=3;
  - default SYNC value.
- The bridge and a future TX framer import the same package.
- One natural sub-module, usb_sat_counter (width-parameterised, saturating, with increment enable). It is instantiated twice, for frame_count and drop_count.

Test Plan:
- Good frame: words 16'hA503, 16'h0001, 16'h0002, 16'h0003, check 16'hA509, PAY_READY=1 → PAY_DATA 1,2,3 with PAY_LAST on 3; FRAME_OK pulse; frame_count=1.
- Bad checksum: same frame with check 16'hA50A → 3 payload words out; FRAME_ERR with ERR_CODE=0; frame_count unchanged.
- Hunt and drop: 16'h1234, 16'hFFFF, then a valid 1-word frame 16'hA501, 16'h00FF, 16'hA600 → drop_count=2; FRAME_OK.
- Backpressure: PAY_READY=0 for 5 cycles during a 3-word frame → IN_READY=0 after the first payload word; PAY_DATA held stable; no timeout with TIMEOUT=4; frame completes OK after release.
- Errors:
  - Header 16'hA500 → FRAME_ERR code 1.
  - Frame 16'hA502, then word with IN_BE=2'b01 → FRAME_ERR code 2; state returns to HUNT.
- Timeout and reset: header 16'hA502 then silence for TIMEOUT cycles → FRAME_ERR code 3. Repeat, asserting RST mid-payload → all outputs 0 immediately, no FRAME_ERR, next frame decodes OK.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB bridge/framer definitions: framer state encoding, frame error codes
// and the default header sync byte.
package usb_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_CSUM = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_BE   = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/usb_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones.
module usb_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else if (inc_i && (count_q != '1))
            count_q <= count_q + W'(1);
    end

    assign count_o = count_q;

endmodule

// File: rtl/usb_rx_framer.sv
// Delimits bridge read words into [header, payload..., check] frames, forwards
// the payload on a valid/ready stream and pulses per-frame OK/ERR status.
module usb_rx_framer
    import usb_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 1000,
    parameter int         CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      IN_DATA,
    input  logic [1:0]       IN_BE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [15:0]      PAY_DATA,
    output logic             PAY_VALID,
    input  logic             PAY_READY,
    output logic             PAY_LAST,
    output logic             FRAME_OK,
    output logic             FRAME_ERR,
    output logic [1:0]       ERR_CODE,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [15:0]   sum_q, sum_d;
    logic [7:0]    rem_q, rem_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   pay_data_q, pay_data_d;
    logic          pay_valid_q, pay_valid_d;
    logic          pay_last_q, pay_last_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          drop_inc;
    logic          accept, full, tmo_hit;

    // Only a full output register in PAYLOAD can stall; headers and checks never load it.
    assign IN_READY = (state_q != PAYLOAD) || !pay_valid_q || PAY_READY;
    assign accept   = IN_VALID && IN_READY;
    assign full     = (IN_BE == 2'b11);
    assign tmo_hit  = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        timer_d     = timer_q;
        pay_data_d  = pay_data_q;
        pay_last_d  = pay_last_q;
        pay_valid_d = pay_valid_q && !PAY_READY;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        drop_inc    = 1'b0;

        case (state_q)
            HUNT: begin
                timer_d = '0;
                if (accept) begin
                    if (full && (IN_DATA[15:8] == SYNC)) begin
                        if (IN_DATA[7:0] == 8'd0) begin
                            err_d  = 1'b1;
                            code_d = ERR_LEN;
                        end else begin
                            rem_d   = IN_DATA[7:0];
                            sum_d   = IN_DATA;
                            state_d = PAYLOAD;
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            PAYLOAD, CHECK: begin
                if (accept) begin
                    timer_d = '0;
                    if (!full) begin
                        err_d   = 1'b1;
                        code_d  = ERR_BE;
                        state_d = HUNT;
                    end else if (state_q == PAYLOAD) begin
                        pay_data_d  = IN_DATA;
                        pay_valid_d = 1'b1;
                        pay_last_d  = (rem_q == 8'd1);
                        sum_d       = sum_q + IN_DATA;
                        rem_d       = rem_q - 8'd1;
                        if (rem_q == 8'd1)
                            state_d = CHECK;
                    end else begin
                        state_d = HUNT;
                        if (IN_DATA == sum_q) begin
                            ok_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_CSUM;
                        end
                    end
                end else if (IN_READY) begin
                    // A stalled consumer freezes the timer; only a silent bridge times out.
                    if (tmo_hit) begin
                        timer_d = '0;
                        err_d   = 1'b1;
                        code_d  = ERR_TMO;
                        state_d = HUNT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= HUNT;
            sum_q       <= '0;
            rem_q       <= '0;
            timer_q     <= '0;
            pay_data_q  <= '0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            timer_q     <= timer_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_last_q  <= pay_last_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    usb_sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (ok_d),
        .count_o (frame_count)
    );

    usb_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (drop_inc),
        .count_o (drop_count)
    );

    assign PAY_DATA  = pay_data_q;
    assign PAY_VALID = pay_valid_q;
    assign PAY_LAST  = pay_last_q;
    assign FRAME_OK  = ok_q;
    assign FRAME_ERR = err_q;
    assign ERR_CODE  = code_q;

endmodule

// File: tb/tb_usb_rx_framer.sv
// Scoreboard bench for usb_rx_framer: directed frames push expected payload and
// status events; a negedge monitor pops and compares them as the DUT emits.
module tb_usb_rx_framer;
    import usb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] IN_DATA = '0;
    logic [1:0]  IN_BE = 2'b11;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] PAY_DATA;
    logic        PAY_VALID;
    logic        PAY_READY = 1'b1;
    logic        PAY_LAST;
    logic        FRAME_OK;
    logic        FRAME_ERR;
    logic [1:0]  ERR_CODE;
    logic [7:0]  frame_count;
    logic [7:0]  drop_count;

    usb_rx_framer #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .IN_DATA(IN_DATA), .IN_BE(IN_BE), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .PAY_DATA(PAY_DATA), .PAY_VALID(PAY_VALID), .PAY_READY(PAY_READY), .PAY_LAST(PAY_LAST),
        .FRAME_OK(FRAME_OK), .FRAME_ERR(FRAME_ERR), .ERR_CODE(ERR_CODE),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int ncmp = 0;
    int nerr = 0;
    logic [16:0] pay_q[$];   // {last, data}
    logic [2:0]  evt_q[$];   // {ok, code}
    logic [16:0] pe;
    logic [2:0]  ee;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_pay(input logic [15:0] d, input logic last);
        pay_q.push_back({last, d});
    endtask

    task automatic exp_evt(input logic ok, input logic [1:0] code);
        evt_q.push_back({ok, code});
    endtask

    // Bridge model: never strobes IN_VALID while IN_READY is low.
    task automatic send(input logic [15:0] d, input logic [1:0] be = 2'b11);
        int n = 0;
        while (!IN_READY && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!IN_READY) begin
            ncmp++; nerr++;
            $display("FAIL in_ready_wait: got IN_READY=0 after 50 cycles expected 1");
        end
        IN_DATA = d; IN_BE = be; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; IN_BE = 2'b11;
    endtask

    task automatic drain();
        int n = 0;
        while ((pay_q.size() != 0 || evt_q.size() != 0) && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain_pending", pay_q.size() + evt_q.size(), 0);
        repeat (2) begin @(posedge CLK); #1; end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (PAY_VALID && PAY_READY) begin
                if (pay_q.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL pay_unexpected: got %h last=%b expected none", PAY_DATA, PAY_LAST);
                end else begin
                    pe = pay_q.pop_front();
                    chk("pay_word", {15'd0, PAY_LAST, PAY_DATA}, {15'd0, pe});
                end
            end
            if (FRAME_OK && FRAME_ERR) begin
                ncmp++; nerr++;
                $display("FAIL ok_err_both: got OK=1 ERR=1 expected exclusive");
            end else if (FRAME_OK || FRAME_ERR) begin
                if (evt_q.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL evt_unexpected: got OK=%b ERR=%b code=%0d expected none",
                             FRAME_OK, FRAME_ERR, ERR_CODE);
                end else begin
                    ee = evt_q.pop_front();
                    chk("frame_evt", {29'd0, FRAME_OK, (FRAME_OK ? 2'b00 : ERR_CODE)}, {29'd0, ee});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pay_valid", PAY_VALID, 0);
        chk("rst_pay_data", PAY_DATA, 0);
        chk("rst_ok_err", {FRAME_OK, FRAME_ERR, ERR_CODE}, 0);
        chk("rst_counts", {frame_count, drop_count}, 0);
        chk("rst_in_ready", IN_READY, 1);
        RST = 1'b0;
        @(posedge CLK); #1;

        // good frame
        exp_pay(16'h0001, 0); exp_pay(16'h0002, 0); exp_pay(16'h0003, 1); exp_evt(1, 0);
        send(16'hA503); send(16'h0001); send(16'h0002); send(16'h0003); send(16'hA509);
        drain();
        chk("good_frame_count", frame_count, 1);

        // bad checksum
        exp_pay(16'h0001, 0); exp_pay(16'h0002, 0); exp_pay(16'h0003, 1); exp_evt(0, ERR_CSUM);
        send(16'hA503); send(16'h0001); send(16'h0002); send(16'h0003); send(16'hA50A);
        drain();
        chk("csum_frame_count", frame_count, 1);
        chk("csum_err_code", ERR_CODE, 0);

        // hunt and drop
        exp_pay(16'h00FF, 1); exp_evt(1, 0);
        send(16'h1234); send(16'hFFFF); send(16'hA501); send(16'h00FF); send(16'hA600);
        drain();
        chk("hunt_drop_count", drop_count, 2);
        chk("hunt_frame_count", frame_count, 2);

        // backpressure with TIMEOUT=4 and a 5-cycle stall
        exp_pay(16'h0010, 0); exp_pay(16'h0020, 0); exp_pay(16'h0030, 1); exp_evt(1, 0);
        PAY_READY = 1'b0;
        send(16'hA503); send(16'h0010);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", IN_READY, 0);
            chk("bp_hold", {PAY_VALID, PAY_LAST, PAY_DATA}, {1'b1, 1'b0, 16'h0010});
            @(posedge CLK); #1;
        end
        PAY_READY = 1'b1;
        send(16'h0020); send(16'h0030); send(16'hA563);
        drain();
        chk("bp_frame_count", frame_count, 3);

        // LEN=0 header
        exp_evt(0, ERR_LEN);
        send(16'hA500);
        drain();
        chk("len0_err_code", ERR_CODE, 1);
        chk("len0_drop_count", drop_count, 2);

        // partial BE, then a frame proves the return to HUNT
        exp_evt(0, ERR_BE);
        send(16'hA502); send(16'h1234, 2'b01);
        exp_pay(16'h0005, 1); exp_evt(1, 0);
        send(16'hA501); send(16'h0005); send(16'hA506);
        drain();
        chk("be_frame_count", frame_count, 4);
        chk("be_drop_count", drop_count, 2);
        chk("be_code_held", ERR_CODE, 2);

        // timeout
        exp_evt(0, ERR_TMO);
        send(16'hA502);
        drain();
        chk("tmo_err_code", ERR_CODE, 3);
        chk("tmo_frame_count", frame_count, 4);

        // reset mid-payload while a word sits in the output register
        PAY_READY = 1'b0;
        send(16'hA502); send(16'h0007);
        chk("pre_rst_pay_valid", PAY_VALID, 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_outputs", {PAY_VALID, PAY_LAST, FRAME_OK, FRAME_ERR, ERR_CODE}, 0);
        chk("mid_rst_data", PAY_DATA, 0);
        chk("mid_rst_counts", {frame_count, drop_count}, 0);
        PAY_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        exp_pay(16'h0042, 1); exp_evt(1, 0);
        send(16'hA501); send(16'h0042); send(16'hA543);
        drain();
        chk("post_rst_frame_count", frame_count, 1);
        chk("post_rst_drop_count", drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
